// File: rtl/serial_frame_arbiter.sv
// serial_frame_arbiter: round-robin sharing of one serial frame transmitter
// between N requesters. The winning frame is latched at grant, the transmitter
// gets a one-cycle start, and the word it selects by index is muxed out.
// Optional feature macro: SERIAL_ARB_TIMEOUT_EN (adds TIMEOUT parameter and
// timeout port; a BUSY phase that stalls for TIMEOUT cycles is abandoned).
module serial_frame_arbiter #(
    parameter int unsigned N           = 2,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned WORDS       = 2,
    parameter int unsigned INDEX_WIDTH = 1
`ifdef SERIAL_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT     = 1024
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N-1:0]                 req,
    input  logic [N*WIDTH*WORDS-1:0]     reqData,
    output logic [N-1:0]                 grant,
    output logic [N-1:0]                 done,
    output logic                         start,
    output logic [WIDTH-1:0]             word,
    input  logic [INDEX_WIDTH-1:0]       index,
    input  logic                         sendReadyAtNext,
    output logic                         busy
`ifdef SERIAL_ARB_TIMEOUT_EN
    ,
    output logic                         timeout
`endif
);

    localparam int unsigned F     = WIDTH * WORDS;
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } state_t;

    state_t           state, state_d;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
    logic [PTR_W-1:0] winner, winner_d;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] next_ptr;
    logic             pick_valid;
    logic [F-1:0]     frame, frame_d;
    logic [F-1:0]     pick_frame;
    logic             seen_busy, seen_busy_d;
    logic [N-1:0]     grant_d, done_d;
    logic             start_d, busy_d;
`ifdef SERIAL_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             timeout_d;
`endif

    // Cyclic search for the first requester at or after the round-robin pointer
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!pick_valid && req[PTR_W'((32'(rr_ptr) + k) % N)]) begin
                pick       = PTR_W'((32'(rr_ptr) + k) % N);
                pick_valid = 1'b1;
            end
        end
    end

    // Frame of the candidate winner, taken straight from the flattened bus
    always_comb begin
        pick_frame = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(pick) == i) begin
                pick_frame = reqData[i*F +: F];
            end
        end
    end

    // Word follows the transmitter's index in the same cycle; word 0 is the MSB word
    always_comb begin
        word = '0;
        if (state == BUSY) begin
            for (int unsigned w = 0; w < WORDS; w++) begin
                if (32'(index) == w) begin
                    word = frame[(WORDS-1-w)*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign next_ptr = PTR_W'((32'(winner) + 1) % N);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        winner_d    = winner;
        frame_d     = frame;
        seen_busy_d = seen_busy;
        grant_d     = '0;
        done_d      = '0;
`ifdef SERIAL_ARB_TIMEOUT_EN
        cnt_d       = cnt;
        timeout_d   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    winner_d = pick;
                    frame_d  = pick_frame;
                    grant_d  = N'(1) << pick;
                    state_d  = START;
                end
            end
            START: begin
                seen_busy_d = 1'b0;
`ifdef SERIAL_ARB_TIMEOUT_EN
                cnt_d       = '0;
`endif
                state_d     = BUSY;
            end
            BUSY: begin
                // Ready is only trusted once the transmitter has been seen busy
                if (seen_busy && sendReadyAtNext) begin
                    done_d   = N'(1) << winner;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else begin
                    if (!sendReadyAtNext) begin
                        seen_busy_d = 1'b1;
                    end
`ifdef SERIAL_ARB_TIMEOUT_EN
                    if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        rr_ptr_d  = next_ptr;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            frame     <= '0;
            seen_busy <= 1'b0;
            grant     <= '0;
            done      <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_ARB_TIMEOUT_EN
            cnt       <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            winner    <= winner_d;
            frame     <= frame_d;
            seen_busy <= seen_busy_d;
            grant     <= grant_d;
            done      <= done_d;
            start     <= start_d;
            busy      <= busy_d;
`ifdef SERIAL_ARB_TIMEOUT_EN
            cnt       <= cnt_d;
            timeout   <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Bench for serial_frame_arbiter: a bit-serial transmitter/receiver model
// drives index/sendReadyAtNext, and a round-robin scoreboard predicts grants,
// done pulses and the reassembled frames.
module tb_serial_frame_arbiter;

    localparam int unsigned N           = 2;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned WORDS       = 2;
    localparam int unsigned INDEX_WIDTH = 1;
    localparam int unsigned F           = WIDTH * WORDS;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [N-1:0]           req;
    logic [N*F-1:0]         reqData;
    logic [N-1:0]           grant;
    logic [N-1:0]           done;
    logic                   start;
    logic [WIDTH-1:0]       word;
    logic [INDEX_WIDTH-1:0] index;
    logic                   sendReadyAtNext;
    logic                   busy;
`ifdef SERIAL_ARB_TIMEOUT_EN
    logic                   timeout;
`endif

    serial_frame_arbiter #(
        .N(N), .WIDTH(WIDTH), .WORDS(WORDS), .INDEX_WIDTH(INDEX_WIDTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .reqData(reqData),
        .grant(grant),
        .done(done),
        .start(start),
        .word(word),
        .index(index),
        .sendReadyAtNext(sendReadyAtNext),
        .busy(busy)
`ifdef SERIAL_ARB_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    always #5 clock = ~clock;

    // Transmitter model: idles with ready high, sends each word MSB first
    logic                   tx_on;
    logic                   tx_hold;
    logic                   tx_kick;
    logic [INDEX_WIDTH-1:0] tx_idx;
    int                     tx_bit;
    logic [F-1:0]           rx_shift;

    always @(posedge clock) begin
        if (reset) begin
            tx_on  <= 1'b0;
            tx_idx <= '0;
            tx_bit <= 0;
        end else if (tx_on) begin
            rx_shift <= {rx_shift[F-2:0], word[WIDTH-1-tx_bit]};
            if (tx_bit == WIDTH - 1) begin
                tx_bit <= 0;
                if (tx_idx == INDEX_WIDTH'(WORDS - 1)) tx_on <= 1'b0;
                else tx_idx <= tx_idx + 1'b1;
            end else begin
                tx_bit <= tx_bit + 1;
            end
        end else if ((start && !tx_hold) || tx_kick) begin
            tx_on  <= 1'b1;
            tx_idx <= '0;
            tx_bit <= 0;
        end
    end

    assign index           = tx_idx;
    assign sendReadyAtNext = !tx_on || (tx_bit == WIDTH - 1 && tx_idx == INDEX_WIDTH'(WORDS - 1));

    // Scoreboard state
    int             n_checks = 0;
    int             n_pass   = 0;
    int             exp_ptr;
    int             cur_w;
    int             n_grants;
    int             n_done;
    int             n_starts;
    logic           pending;
    logic [F-1:0]   exp_frame;
    logic [F-1:0]   last_rx;
    logic [N-1:0]   in_flight;
    logic [N-1:0]   grant_q[$];
    logic [F-1:0]   rx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Round-robin rule: first requester at or after the pointer, cyclically
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Observe one cycle of DUT outputs against the reference model
    task automatic sample();
        int w;
        if (reset) begin
            exp_ptr   = 0;
            pending   = 1'b0;
            in_flight = '0;
            return;
        end
        if (start) n_starts++;
        if (start && grant == '0) check("stray_start", 32'(start), 32'd0);
        if (grant != '0) begin
            w = rr_pick(req, exp_ptr);
            check("grant", 32'(grant), 32'd1 << w);
            check("start_at_grant", 32'(start), 32'd1);
            check("grant_overlap", 32'(pending), 32'd0);
            pending      = 1'b1;
            cur_w        = w;
            exp_frame    = reqData[w*F +: F];
            in_flight[w] = 1'b1;
            n_grants++;
            grant_q.push_back(grant);
        end
        if (done != '0) begin
            check("done", 32'(done), pending ? (32'd1 << cur_w) : 32'd0);
            check("frame", 32'(rx_shift), 32'(exp_frame));
            last_rx = rx_shift;
            rx_q.push_back(rx_shift);
            n_done++;
            if (pending) begin
                exp_ptr          = (cur_w + 1) % N;
                in_flight[cur_w] = 1'b0;
            end
            pending = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clock);
        sample();
    endtask

    task automatic wait_done(input string tag, input int k, input int bound, input logic drop);
        int target;
        int c;
        target = n_done + k;
        c = 0;
        while (n_done < target && c < bound) begin
            step();
            if (drop) req = req & ~done;
            c++;
        end
        check(tag, 32'(n_done), 32'(target));
    endtask

    task automatic wait_grant(input string tag, input int bound);
        int target;
        int c;
        target = n_grants + 1;
        c = 0;
        while (n_grants < target && c < bound) begin
            step();
            c++;
        end
        check(tag, 32'(n_grants), 32'(target));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_word",  32'(word),  32'd0);
        reset    = 1'b0;
        n_starts = 0;
        grant_q.delete();
        rx_q.delete();
    endtask

    initial begin
        int gap[N];
        int c;
        int done_base;

        reset   = 1'b1;
        req     = '0;
        reqData = '0;
        tx_hold = 1'b0;
        tx_kick = 1'b0;
        n_grants = 0;
        n_done   = 0;

        // Single request, one frame reassembled by the receiver
        apply_reset();
        reqData[15:0]  = 16'h76A5;
        reqData[31:16] = 16'($urandom);
        req = 2'b01;
        wait_done("t1_done", 1, 100, 1'b1);
        check("t1_rx", 32'(last_rx), 32'h76A5);
        check("t1_starts", 32'(n_starts), 32'd1);
        check("t1_grants", 32'(grant_q.size()), 32'd1);

        // Both held: strict alternation starting at requester 0
        apply_reset();
        reqData = {16'hABCD, 16'h1234};
        req = 2'b11;
        wait_done("t2_done", 3, 200, 1'b0);
        req = '0;
        if (grant_q.size() >= 3 && rx_q.size() >= 3) begin
            check("t2_g0", 32'(grant_q[0]), 32'b01);
            check("t2_g1", 32'(grant_q[1]), 32'b10);
            check("t2_g2", 32'(grant_q[2]), 32'b01);
            check("t2_f0", 32'(rx_q[0]), 32'h1234);
            check("t2_f1", 32'(rx_q[1]), 32'hABCD);
            check("t2_f2", 32'(rx_q[2]), 32'h1234);
        end

        // Transmitter sitting with ready high must not complete the frame
        apply_reset();
        tx_hold = 1'b1;
        reqData[15:0] = 16'hC35A;
        req = 2'b01;
        wait_grant("t3_grant", 20);
        done_base = n_done;
        repeat (12) step();
        check("t3_no_done", 32'(n_done - done_base), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        tx_hold = 1'b0;
        tx_kick = 1'b1;
        step();
        tx_kick = 1'b0;
        wait_done("t3_done", 1, 100, 1'b1);
        check("t3_rx", 32'(last_rx), 32'hC35A);
        check("t3_starts", 32'(n_starts), 32'd1);

        // Frame latched at grant; later bus changes are ignored
        apply_reset();
        reqData[15:0] = 16'h00FF;
        req = 2'b01;
        wait_grant("t4_grant", 20);
        reqData[15:0] = 16'hFF00;
        wait_done("t4_done", 1, 100, 1'b1);
        check("t4_rx", 32'(last_rx), 32'h00FF);

        // Reset after the first word: no done, pointer back to 0
        apply_reset();
        reqData[15:0] = 16'h5A5A;
        req = 2'b01;
        wait_grant("t5_grant", 20);
        c = 0;
        while (tx_idx != 1'b1 && c < 40) begin
            step();
            c++;
        end
        check("t5_word0_sent", 32'(tx_idx), 32'd1);
        done_base = n_done;
        reset = 1'b1;
        step();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_start", 32'(start), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        reset = 1'b0;
        grant_q.delete();
        reqData[31:16] = 16'h3C3C;
        req = 2'b10;
        wait_grant("t5_grant2", 20);
        if (grant_q.size() >= 1) check("t5_g", 32'(grant_q[0]), 32'b10);
        wait_done("t5_done2", 1, 100, 1'b1);
        check("t5_rx", 32'(last_rx), 32'h3C3C);
        check("t5_ndone", 32'(n_done - done_base), 32'd1);

        // Randomized requesters, data churn and mid-frame request drops
        apply_reset();
        done_base = n_done;
        for (int i = 0; i < N; i++) gap[i] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) reqData[i*F +: F] = F'($urandom);
                if (in_flight[i]) begin
                    if (req[i] && $urandom_range(31) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    else if ($urandom_range(2) == 0) req[i] = 1'b1;
                end
            end
            step();
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    req[i] = 1'b0;
                    gap[i] = $urandom_range(3);
                end
            end
        end
        req = '0;
        c = 0;
        while (pending && c < 100) begin
            step();
            c++;
        end
        check("rand_drain", 32'(pending), 32'd0);
        check("rand_frames", 32'(n_done - done_base >= 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
